// File: rtl/mm6532_arb_pkg.sv
// mm6532_arb_pkg: shared states, command layout and RIOT bus park/select values for the arbiter.
package mm6532_arb_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, ACKS, GAPW} state_t;
   typedef struct packed {
      logic       r_w;
      logic       rs_n;
      logic [6:0] a;
      logic [7:0] wd;
   } cmd_t;
   localparam logic [1:0] CS_SEL  = 2'b01;
   localparam logic [1:0] CS_PARK = 2'b00;
   // Parked bus is a harmless DRA read: no write, no flag clear.
   localparam cmd_t PARK_CMD = cmd_t'{r_w: 1'b1, rs_n: 1'b1, a: 7'h00, wd: 8'h00};
   localparam logic [6:0] RIOT_DRA   = 7'h00;
   localparam logic [6:0] RIOT_FLAG  = 7'h05;
   localparam logic [6:0] RIOT_TIM1T = 7'h14;
endpackage

// File: rtl/mm6532_arb_rr_pick.sv
// mm6532_arb_rr_pick: combinational round-robin pick with lock override.
module mm6532_arb_rr_pick #(
   parameter int N = 2
) (
   input  logic [N-1:0] req,
   input  logic [1:0]   ptr,
   input  logic         lock,
   input  logic [1:0]   lock_id,
   output logic [N-1:0] win,
   output logic [1:0]   win_id,
   output logic         valid
);
   int best, d;
   always_comb begin
      best = N;
      d = 0;
      win_id = '0;
      for (int i = 0; i < N; i++) begin
         d = (i + 2 * N - int'(ptr) - 1) % N;
         if (req[i] && d < best) begin
            best = d;
            win_id = 2'(i);
         end
      end
      for (int i = 0; i < N; i++)
         if (lock && req[i] && lock_id == 2'(i)) begin
            best = 0;
            win_id = 2'(i);
         end
      valid = best < N;
      win = valid ? N'(1) << win_id : '0;
   end
endmodule

// File: rtl/mm6532_arb.sv
// mm6532_arb: round-robin sequencer sharing one RIOT port as isolated single-cycle bus accesses.
module mm6532_arb
   import mm6532_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int GAP  = 0
) (
   input  logic              CLK,
   input  logic              RES,
   input  logic [NREQ-1:0]   REQ,
   input  logic [NREQ-1:0]   REQ_R_W,
   input  logic [NREQ-1:0]   REQ_RS_N,
   input  logic [NREQ*7-1:0] REQ_A,
   input  logic [NREQ*8-1:0] REQ_WD,
   input  logic [NREQ-1:0]   REQ_LOCK,
   output logic [NREQ-1:0]   GNT,
   output logic [NREQ-1:0]   ACK,
   output logic [7:0]        RD,
   output logic              RIOT_R_W,
   output logic [1:0]        RIOT_CS,
   output logic              RIOT_RS_N,
   output logic [6:0]        RIOT_A,
   output logic [7:0]        RIOT_DI,
   input  logic [7:0]        RIOT_DO
);
   state_t state, nxt;
   logic [1:0] ptr, w_q, win_id;
   logic [NREQ-1:0] win;
   logic valid, lock_q, take;
   logic [3:0] cnt;
   cmd_t cmd_n;

   mm6532_arb_rr_pick #(.N(NREQ)) u_pick (
      .req(REQ), .ptr(ptr), .lock(lock_q), .lock_id(w_q),
      .win(win), .win_id(win_id), .valid(valid)
   );

   always_comb begin
      cmd_n = PARK_CMD;
      for (int i = 0; i < NREQ; i++)
         if (win[i]) cmd_n = {REQ_R_W[i], REQ_RS_N[i], REQ_A[7*i +: 7], REQ_WD[8*i +: 8]};
      take = valid && (state == IDLE || (state == ACKS && GAP == 0));
      nxt = take ? ACCESS :
            state == ACCESS ? ACKS :
            (state == ACKS && GAP != 0) ? GAPW :
            (state == GAPW && cnt != 4'(GAP - 1)) ? GAPW : IDLE;
   end

   // Outputs are registered one cycle ahead from the next-state decision.
   always_ff @(posedge CLK) begin
      if (RES) begin
         state <= IDLE;
         GNT <= '0;
         ACK <= '0;
         RD <= 8'h00;
         {RIOT_R_W, RIOT_RS_N, RIOT_A, RIOT_DI} <= PARK_CMD;
         RIOT_CS <= CS_PARK;
         ptr <= 2'(NREQ - 1);
         w_q <= '0;
         lock_q <= 1'b0;
         cnt <= '0;
      end else begin
         state <= nxt;
         GNT <= take ? win : nxt == ACKS ? GNT : '0;
         ACK <= nxt == ACKS ? GNT : '0;
         {RIOT_R_W, RIOT_RS_N, RIOT_A, RIOT_DI} <= take ? cmd_n : PARK_CMD;
         RIOT_CS <= take ? CS_SEL : CS_PARK;
         cnt <= state == GAPW ? cnt + 4'd1 : '0;
         if (take) w_q <= win_id;
         if (state == ACCESS) begin
            if (RIOT_R_W) RD <= RIOT_DO;
            ptr <= w_q;
            lock_q <= |(REQ_LOCK & GNT);
         end
      end
   end
endmodule
